register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 140 ++++++++++++++
 tb/tb_register_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file
//   Two-read / one-write register file with a per-register busy scoreboard.
//   Both reads, the write and the reserve are accepted in the same cycle.
//   Reads are write-first and registered: data and busy appear one cycle
//   after rd_en_x and hold their last values while rd_en_x is low.
//   The busy bit of a register is set by rsv_en and cleared by wr_en.
//   When both target the same register in one cycle, the set wins.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rd_en_x, rd_addr_x          read request / address, ports A and B
//   rd_data_x, rd_valid_x       registered read data / valid, ports A and B
//   busy_x                      busy bit of the register read, ports A and B
//   wr_en, wr_addr, wr_data     write request
//   rsv_en, rsv_addr            reserve request (marks a register busy)
//
// Configuration
//   REGISTER_FILE_ZERO_REG_EN   when defined, register 0 is hardwired:
//                               it reads 0, ignores writes and reserves,
//                               and its busy bit reads 0.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  output logic                  busy_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b,
  output logic                  busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage lives in flops rather than RAM: every entry must clear
  // immediately on an asynchronous reset.
  logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d  [DEPTH];
  logic                  busy_q [DEPTH];
  logic                  busy_d [DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d;
  logic                  rd_valid_b_q, rd_valid_b_d;
  logic                  busy_a_q, busy_a_d;
  logic                  busy_b_q, busy_b_d;

  // Per-entry next state. The clear from a write is applied before the set
  // from a reserve, so a simultaneous reserve leaves the register busy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
`ifdef REGISTER_FILE_ZERO_REG_EN
    localparam bit HARDWIRED = (gi == 0);
`else
    localparam bit HARDWIRED = 1'b0;
`endif

    always_comb begin
      mem_d[gi]  = mem_q[gi];
      busy_d[gi] = busy_q[gi];
      if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
        mem_d[gi]  = wr_data;
        busy_d[gi] = 1'b0;
      end
      if (rsv_en && (rsv_addr == ADDR_WIDTH'(gi))) begin
        busy_d[gi] = 1'b1;
      end
      if (HARDWIRED) begin
        mem_d[gi]  = '0;
        busy_d[gi] = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi]  <= '0;
        busy_q[gi] <= 1'b0;
      end else begin
        mem_q[gi]  <= mem_d[gi];
        busy_q[gi] <= busy_d[gi];
      end
    end
  end

  // Reading the post-update state gives write-first data and a busy bit
  // that already reflects this cycle's set/clear.
  always_comb begin
    rd_data_a_d  = rd_data_a_q;
    busy_a_d     = busy_a_q;
    rd_valid_a_d = rd_en_a;
    if (rd_en_a) begin
      rd_data_a_d = mem_d[rd_addr_a];
      busy_a_d    = busy_d[rd_addr_a];
    end
    rd_data_b_d  = rd_data_b_q;
    busy_b_d     = busy_b_q;
    rd_valid_b_d = rd_en_b;
    if (rd_en_b) begin
      rd_data_b_d = mem_d[rd_addr_b];
      busy_b_d    = busy_d[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      busy_a_q     <= 1'b0;
      busy_b_q     <= 1'b0;
    end else begin
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      busy_a_q     <= busy_a_d;
      busy_b_q     <= busy_b_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
  assign busy_a     = busy_a_q;
  assign busy_b     = busy_b_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed and randomized stimulus for register_file, checked against a
//   reference model holding the register contents and busy bits as plain
//   arrays. Each cycle the model applies the write, then the clear/set of the
//   busy bits, and a read returns the resulting state of the addressed
//   register.
module tb_register_file;

`ifdef REGISTER_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en_a, rd_en_b, wr_en, rsv_en;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  // Reference model state and expected outputs.
  logic [31:0] m_mem  [16];
  logic        m_busy [16];
  logic [31:0] e_da, e_db;
  logic        e_va, e_vb, e_ba, e_bb;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .busy_a     (busy_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b),
    .busy_b     (busy_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " rd_data_a"},  rd_data_a, e_da);
    chk({tag, " rd_data_b"},  rd_data_b, e_db);
    chk({tag, " rd_valid_a"}, 32'(rd_valid_a), 32'(e_va));
    chk({tag, " rd_valid_b"}, 32'(rd_valid_b), 32'(e_vb));
    chk({tag, " busy_a"},     32'(busy_a), 32'(e_ba));
    chk({tag, " busy_b"},     32'(busy_b), 32'(e_bb));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    e_da = 32'h0; e_db = 32'h0;
    e_va = 1'b0;  e_vb = 1'b0;
    e_ba = 1'b0;  e_bb = 1'b0;
  endtask

  task automatic idle_inputs();
    rd_en_a = 1'b0; rd_addr_a = 4'h0;
    rd_en_b = 1'b0; rd_addr_b = 4'h0;
    wr_en   = 1'b0; wr_addr   = 4'h0; wr_data = 32'h0;
    rsv_en  = 1'b0; rsv_addr  = 4'h0;
  endtask

  // One clock cycle: drive the requests, let the edge pass, update the model
  // and compare every output.
  task automatic step(input string tag,
                      input logic ea, input logic [3:0] aa,
                      input logic eb, input logic [3:0] ab,
                      input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra);
    rd_en_a = ea; rd_addr_a = aa;
    rd_en_b = eb; rd_addr_b = ab;
    wr_en   = we; wr_addr   = wa; wr_data = wd;
    rsv_en  = re; rsv_addr  = ra;
    @(posedge clk);
    #1;
    if (we && !(ZERO_REG && wa == 4'd0)) m_mem[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (re && !(ZERO_REG && ra == 4'd0)) m_busy[ra] = 1'b1;
    e_va = ea;
    e_vb = eb;
    if (ea) begin e_da = m_mem[aa]; e_ba = m_busy[aa]; end
    if (eb) begin e_db = m_mem[ab]; e_bb = m_busy[ab]; end
    $display("step %-10s rdA=%0b@%0d rdB=%0b@%0d wr=%0b@%0d:%h rsv=%0b@%0d -> A=%h/%0b/%0b B=%h/%0b/%0b",
             tag, ea, aa, eb, ab, we, wa, wd, re, ra,
             rd_data_a, rd_valid_a, busy_a, rd_data_b, rd_valid_b, busy_b);
    chk_all(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;

    // Reset state
    #12;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("post_rel");

    // Write then read
    step("wr5",   0, 0, 0, 0, 1, 4'd5, 32'hDEADBEEF, 0, 0);
    step("rd5",   1, 4'd5, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("wtr data", rd_data_a, 32'hDEADBEEF);
    chk("wtr valid", 32'(rd_valid_a), 32'd1);
    step("idle",  0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("valid drop", 32'(rd_valid_a), 32'd0);
    chk("hold data", rd_data_a, 32'hDEADBEEF);

    // Bypass on both ports
    step("bypass", 1, 4'd3, 1, 4'd3, 1, 4'd3, 32'h12345678, 0, 0);
    chk("byp A", rd_data_a, 32'h12345678);
    chk("byp B", rd_data_b, 32'h12345678);

    // Scoreboard
    step("rsv7",    0, 0, 0, 0, 0, 0, 32'h0, 1, 4'd7);
    step("rd7",     1, 4'd7, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("sb busy set", 32'(busy_a), 32'd1);
    step("wrrsv7",  0, 0, 0, 0, 1, 4'd7, 32'h0000_0077, 1, 4'd7);
    step("rd7b",    1, 4'd7, 1, 4'd7, 0, 0, 32'h0, 0, 0);
    chk("sb set wins", 32'(busy_b), 32'd1);
    step("wr7",     0, 0, 0, 0, 1, 4'd7, 32'h0000_0777, 0, 0);
    step("rd7c",    1, 4'd7, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("sb cleared", 32'(busy_a), 32'd0);
    chk("sb data", rd_data_a, 32'h0000_0777);

    // Register 0 behaviour
    step("wrrsv0", 0, 0, 0, 0, 1, 4'd0, 32'hFFFFFFFF, 1, 4'd0);
    step("rd0",    1, 4'd0, 1, 4'd0, 0, 0, 32'h0, 0, 0);
    if (ZERO_REG) begin
      chk("zreg data", rd_data_a, 32'h0);
      chk("zreg busy", 32'(busy_b), 32'd0);
    end else begin
      chk("reg0 data", rd_data_a, 32'hFFFFFFFF);
      chk("reg0 busy", 32'(busy_b), 32'd1);
    end

    // Random traffic, narrow address range so collisions are frequent
    for (int n = 0; n < 300; n++) begin
      step("rand",
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 32'($urandom()),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
    end

    // Reset mid-operation
    for (int i = 0; i < 16; i++) begin
      step("fill", 0, 0, 0, 0, 1, 4'(i), 32'hA5A5A5A5, 0, 0);
    end
    step("rd3",  1, 4'd3, 1, 4'd9, 0, 0, 32'h0, 1, 4'd9);
    chk("pre-rst data", rd_data_b, 32'hA5A5A5A5);
    rd_en_a = 1'b1; rd_addr_a = 4'd4;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    idle_inputs();
    #1;
    chk_all("rel_first");
    for (int i = 0; i < 16; i += 2) begin
      step("rd_clr", 1, 4'(i), 1, 4'(i + 1), 0, 0, 32'h0, 0, 0);
      chk("clr data A", rd_data_a, 32'h0);
      chk("clr busy B", 32'(busy_b), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
